mult_8x8_seq_ctrl: RTL

//  Sequencing controller for an 8x8 approximate multiply built from ONE shared 4x4
//  sub-multiplier (LM-style) instead of four instances. Latches operands, issues the

---
 rtl/mult_8x8_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mult_8x8_seq_ctrl.sv
// mult_8x8_seq_ctrl
//   Sequencing controller for an 8x8 approximate multiply that time-shares one external
//   combinational 4x4 sub-multiplier. An accepted operand pair is split into four nibble
//   quadrants (Q0..Q3). They are issued one per cycle, each with its own approximation
//   mode. The shifted partial products are summed into a 16-bit accumulator, and the
//   product is returned over a valid/ready handshake.
//
// Build option
//   ZERO_SKIP_EN : when defined, quadrants with a zero A or B nibble are not issued.
//                  If every quadrant is zero, the result is returned one cycle after accept.
//
// Parameters
//   QMODE      2-bit mode per quadrant, [1:0]=Q0 .. [7:6]=Q3 (0=LM-NC, 2=LM-2)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand request
//   in_ready   ready to accept operands (idle only)
//   A, B       8-bit operands, sampled on in_valid & in_ready
//   out_valid  R valid, held until out_ready
//   out_ready  consumer accepts R
//   R          16-bit product
//   busy       operation in flight (calculating or holding a result)
//   sub_a      sub-multiplier nibble operand A
//   sub_b      sub-multiplier nibble operand B
//   sub_sel    sub-multiplier mode for the issued quadrant
//   sub_r      sub-multiplier result, combinational from sub_a/sub_b/sub_sel

module mult_8x8_seq_ctrl #(
   parameter logic [7:0] QMODE = 8'hA0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] R,
   output logic        busy,
   output logic [3:0]  sub_a,
   output logic [3:0]  sub_b,
   output logic [1:0]  sub_sel,
   input  logic [7:0]  sub_r
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e      state;
   logic [7:0]  a_q;
   logic [7:0]  b_q;
   logic [15:0] acc;
   logic [1:0]  qcnt;

   // Q1 and Q3 take the high nibble of B; Q2 and Q3 take the high nibble of A.
   function automatic logic [3:0] nib_a(input logic [1:0] q, input logic [7:0] a);
      return q[1] ? a[7:4] : a[3:0];
   endfunction

   function automatic logic [3:0] nib_b(input logic [1:0] q, input logic [7:0] b);
      return q[0] ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [1:0] sel_of(input logic [1:0] q);
      return QMODE[{q, 1'b0} +: 2];
   endfunction

   // Lowest quadrant at or after 'start' that must be issued. Returns {found, quadrant}.
   function automatic logic [2:0] find_q(input logic [2:0] start, input logic [7:0] a,
                                         input logic [7:0] b);
      logic [2:0] res;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (3'(i) >= start) begin
`ifdef ZERO_SKIP_EN
            if (nib_a(2'(i), a) != 4'd0 && nib_b(2'(i), b) != 4'd0) begin
               res = {1'b1, 2'(i)};
            end
`else
            res = {1'b1, 2'(i)};
`endif
         end
      end
      return res;
   endfunction

   logic [2:0]  first_q;
   logic [2:0]  next_q;
   logic [15:0] pp;
   logic [15:0] acc_nxt;

   always_comb begin
      first_q = find_q(3'd0, A, B);
      next_q  = find_q({1'b0, qcnt} + 3'd1, a_q, b_q);
      unique case (qcnt)
         2'd0:    pp = {8'b0, sub_r};
         2'd1,
         2'd2:    pp = {4'b0, sub_r, 4'b0};
         default: pp = {sub_r, 8'b0};
      endcase
      // Wraps modulo 2^16: approximate partial products may overshoot the true product.
      acc_nxt = acc + pp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         R         <= 16'd0;
         acc       <= 16'd0;
         qcnt      <= 2'd0;
         a_q       <= 8'd0;
         b_q       <= 8'd0;
         sub_a     <= 4'd0;
         sub_b     <= 4'd0;
         sub_sel   <= 2'd0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid && in_ready) begin
                  a_q      <= A;
                  b_q      <= B;
                  acc      <= 16'd0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (first_q[2]) begin
                     state   <= StCalc;
                     qcnt    <= first_q[1:0];
                     sub_a   <= nib_a(first_q[1:0], A);
                     sub_b   <= nib_b(first_q[1:0], B);
                     sub_sel <= sel_of(first_q[1:0]);
                  end else begin
                     // Nothing to issue: the product is zero.
                     state     <= StDone;
                     R         <= 16'd0;
                     out_valid <= 1'b1;
                  end
               end
            end
            StCalc: begin
               acc <= acc_nxt;
               if (next_q[2]) begin
                  qcnt    <= next_q[1:0];
                  sub_a   <= nib_a(next_q[1:0], a_q);
                  sub_b   <= nib_b(next_q[1:0], b_q);
                  sub_sel <= sel_of(next_q[1:0]);
               end else begin
                  state     <= StDone;
                  R         <= acc_nxt;
                  out_valid <= 1'b1;
                  qcnt      <= 2'd0;
                  sub_a     <= 4'd0;
                  sub_b     <= 4'd0;
                  sub_sel   <= 2'd0;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state     <= StIdle;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
